// File: rtl/led_pattern_engine.sv
// ----------------------------------------------------------------------------
// led_pattern_engine
//
// Holiday-light pattern generator. A one-cycle button pulse latches a lit-LED
// count and an animation mode, then the LED bus shows a static, chasing,
// bouncing or blinking window of that many LEDs. The window advances one step
// every STEP_DIV clocks.
//
// Optional feature macro: LED_PATTERN_BLINK_EN
//   defined   -> mode 3 blinks the pos-0 window on/off on each step
//   undefined -> no blink states are built; mode 3 behaves as mode 0 (STATIC)
//
// Parameters:
//   LED_W    number of LEDs (>= 2)
//   SEL_W    width of count_sel
//   STEP_DIV clocks per animation step (>= 1)
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   button     single-cycle pulse: latch count_sel/mode, restart animation
//   count_sel  requested lit count minus 1
//   mode       0 STATIC, 1 CHASE, 2 BOUNCE, 3 BLINK
//   led        registered LED drive, bit 0 is the lowest LED
//   step       registered one-cycle pulse on each animation advance
// ----------------------------------------------------------------------------
module led_pattern_engine #(
    parameter int LED_W    = 16,
    parameter int SEL_W    = 4,
    parameter int STEP_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             button,
    input  logic [SEL_W-1:0] count_sel,
    input  logic [1:0]       mode,
    output logic [LED_W-1:0] led,
    output logic             step
);

    localparam int POS_W = (LED_W > 1) ? $clog2(LED_W) : 1;
    localparam int LEN_W = SEL_W + 1;
    localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STATIC,
        S_CHASE,
        S_BOUNCE_UP,
        S_BOUNCE_DN
`ifdef LED_PATTERN_BLINK_EN
        ,
        S_BLINK_ON,
        S_BLINK_OFF
`endif
    } state_t;

    state_t           state;
    logic [POS_W-1:0] pos;
    logic [LEN_W-1:0] len_r;
    logic [DIV_W-1:0] div;

    // len contiguous ones starting at bit p, wrapping from MSB back to bit 0.
    function automatic logic [LED_W-1:0] window(input logic [LEN_W-1:0] n,
                                                input logic [POS_W-1:0] p);
        logic [LED_W-1:0]   base;
        logic [2*LED_W-1:0] wide;
        for (int i = 0; i < LED_W; i++) begin
            base[i] = (i < int'(n));
        end
        wide = {{LED_W{1'b0}}, base} << p;
        return wide[LED_W-1:0] | wide[2*LED_W-1:LED_W];
    endfunction

    // Length is formed one bit wider than count_sel so all-ones does not wrap.
    logic [LEN_W-1:0] sel_plus;
    logic [LEN_W-1:0] len_new;
    assign sel_plus = {1'b0, count_sel} + 1'b1;
    assign len_new  = (int'(sel_plus) > LED_W) ? LEN_W'(LED_W) : sel_plus;

    // Highest legal window position for the latched length (0 when all lit).
    logic [POS_W:0] max_pos;
    assign max_pos = (POS_W+1)'(LED_W) - (POS_W+1)'(len_r);

    logic div_term;
    assign div_term = (div == DIV_W'(STEP_DIV - 1));

    state_t start_state;
    always_comb begin
        case (mode)
            2'd1:    start_state = S_CHASE;
            2'd2:    start_state = S_BOUNCE_UP;
`ifdef LED_PATTERN_BLINK_EN
            2'd3:    start_state = S_BLINK_ON;
`endif
            default: start_state = S_STATIC;
        endcase
    end

    // Where the animation goes on the next step.
    state_t           nxt_state;
    logic [POS_W-1:0] nxt_pos;
    logic             nxt_lit;
    // NOTE: every always_comb output gets a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        nxt_state = state;
        nxt_pos   = pos;
        nxt_lit   = 1'b1;
        case (state)
            S_CHASE: begin
                nxt_pos = (pos == POS_W'(LED_W - 1)) ? '0 : pos + 1'b1;
            end
            S_BOUNCE_UP: begin
                if (max_pos == '0) begin
                    nxt_pos = pos;                 // full bar: nothing to move
                end else if ({1'b0, pos} < max_pos) begin
                    nxt_pos = pos + 1'b1;
                end else begin
                    nxt_state = S_BOUNCE_DN;
                    nxt_pos   = pos - 1'b1;
                end
            end
            S_BOUNCE_DN: begin
                if (pos != '0) begin
                    nxt_pos = pos - 1'b1;
                end else begin
                    nxt_state = S_BOUNCE_UP;
                    nxt_pos   = pos + 1'b1;
                end
            end
`ifdef LED_PATTERN_BLINK_EN
            S_BLINK_ON: begin
                nxt_state = S_BLINK_OFF;
                nxt_lit   = 1'b0;
            end
            S_BLINK_OFF: begin
                nxt_state = S_BLINK_ON;
            end
`endif
            default: begin
                nxt_state = state;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pos   <= '0;
            len_r <= '0;
            div   <= '0;
            led   <= '0;
            step  <= 1'b0;
        end else if (button) begin
            // Button beats a coinciding terminal count: restart, no step.
            state <= start_state;
            pos   <= '0;
            len_r <= len_new;
            div   <= '0;
            led   <= window(len_new, '0);
            step  <= 1'b0;
        end else if (state == S_IDLE) begin
            led  <= '0;
            step <= 1'b0;
        end else if (div_term) begin
            div   <= '0;
            state <= nxt_state;
            pos   <= nxt_pos;
            led   <= nxt_lit ? window(len_r, nxt_pos) : '0;
            step  <= 1'b1;
        end else begin
            div  <= div + 1'b1;
            step <= 1'b0;
        end
    end

endmodule
